// File: rtl/pipeline_ctrl.sv
// Stall/flush/PC-select controller for the 5-stage pipeline (RUN / MEM_WAIT).
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipeline_ctrl #(
  parameter int DBITS    = 32,
  parameter int REGBITS  = 4,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REGBITS-1:0] decRs1,
  input  logic [REGBITS-1:0] decRs2,
  input  logic               decUsesRs1,
  input  logic               decUsesRs2,
  input  logic [REGBITS-1:0] exeRd,
  input  logic               exeWrEn,
  input  logic               exeIsLoad,
  input  logic               exeRedirect,
  input  logic               memReq,
  input  logic               memReady,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               pcSelExec,
`ifdef PIPE_CTRL_PERF_EN
  output logic [DBITS-1:0]   perfStallCycles,
  output logic [DBITS-1:0]   perfFlushCount,
  output logic [DBITS-1:0]   perfMemWaitCycles,
`endif
  output logic               memTimeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] cnt_nxt;
  logic       miss;
  logic       load_use;

  assign miss = memReq && !memReady;

  assign load_use = exeIsLoad && exeWrEn &&
                    ((decUsesRs1 && decRs1 == exeRd) ||
                     (decUsesRs2 && decRs2 == exeRd));

  // Count value the next waiting edge would store
  always_comb begin
    cnt_nxt = 8'd1;
    if (state == MEM_WAIT)
      cnt_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  end

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    pcSelExec = 1'b0;
    priority case (1'b1)
      reset: begin
        flushD = 1'b1;
        flushE = 1'b1;
      end
      (state == MEM_WAIT): begin
        stallF = !memReady;
        stallD = !memReady;
        stallE = !memReady;
        stallM = !memReady;
      end
      miss: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
      end
      exeRedirect: begin
        pcSelExec = 1'b1;
        flushD    = 1'b1;
        flushE    = 1'b1;
      end
      load_use: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= 8'd0;
      memTimeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == 8'(MAX_WAIT))
              memTimeout <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (memReady) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= cnt_nxt;
            if (cnt_nxt == 8'(MAX_WAIT))
              memTimeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [DBITS-1:0] ONES = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      perfStallCycles   <= '0;
      perfFlushCount    <= '0;
      perfMemWaitCycles <= '0;
    end else begin
      if (stallF && perfStallCycles != ONES)
        perfStallCycles <= perfStallCycles + 1'b1;
      if (flushE && perfFlushCount != ONES)
        perfFlushCount <= perfFlushCount + 1'b1;
      if (state == MEM_WAIT && perfMemWaitCycles != ONES)
        perfMemWaitCycles <= perfMemWaitCycles + 1'b1;
    end
  end
`else
  logic [DBITS-1:0] unused_dbits;
  assign unused_dbits = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, hand sequences for
// memory wait / timeout / reset, then random traffic against a model.
module tb_pipeline_ctrl;

  localparam int MW = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] decRs1, decRs2, exeRd;
  logic       decUsesRs1, decUsesRs2, exeWrEn, exeIsLoad;
  logic       exeRedirect, memReq, memReady;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, pcSelExec, memTimeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perfStallCycles, perfFlushCount, perfMemWaitCycles;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(.DBITS(32), .REGBITS(4), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .decRs1(decRs1), .decRs2(decRs2),
    .decUsesRs1(decUsesRs1), .decUsesRs2(decUsesRs2),
    .exeRd(exeRd), .exeWrEn(exeWrEn), .exeIsLoad(exeIsLoad),
    .exeRedirect(exeRedirect), .memReq(memReq), .memReady(memReady),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .pcSelExec(pcSelExec),
`ifdef PIPE_CTRL_PERF_EN
    .perfStallCycles(perfStallCycles),
    .perfFlushCount(perfFlushCount),
    .perfMemWaitCycles(perfMemWaitCycles),
`endif
    .memTimeout(memTimeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] rs1, rs2, rd;
    logic       u1, u2, wr, ld, redir, req, rdy;
    logic [6:0] exp;
    logic       to;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // model: waiting flag, cycles waited, sticky timeout, perf tallies
  bit m_wait;
  int m_waited;
  bit m_to;
  int m_stall, m_flush, m_mw;

  function automatic vec_t mk(bit rst, int rs1, int rs2, int rd,
                              bit u1, bit u2, bit wr, bit ld,
                              bit redir, bit req, bit rdy,
                              logic [6:0] exp, bit to);
    vec_t v;
    v.rst = rst; v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.rd = 4'(rd);
    v.u1 = u1; v.u2 = u2; v.wr = wr; v.ld = ld;
    v.redir = redir; v.req = req; v.rdy = rdy;
    v.exp = exp; v.to = to;
    return v;
  endfunction

  // {stallF,stallD,stallE,stallM,flushD,flushE,pcSelExec}
  function automatic logic [6:0] m_out(vec_t v);
    bit hazard;
    hazard = v.ld && v.wr &&
             ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (v.rst) return 7'b0000110;
    if (m_wait) return v.rdy ? 7'b0 : 7'b1111000;
    if (v.req && !v.rdy) return 7'b1111000;
    if (v.redir) return 7'b0000111;
    if (hazard) return 7'b1100010;
    return 7'b0;
  endfunction

  task automatic m_edge(vec_t v, logic [6:0] o);
    if (v.rst) begin
      m_wait = 0; m_waited = 0; m_to = 0;
      m_stall = 0; m_flush = 0; m_mw = 0;
      return;
    end
    m_stall += int'(o[6]);
    m_flush += int'(o[1]);
    m_mw += int'(m_wait);
    if (m_wait && v.rdy) begin
      m_wait = 0; m_waited = 0;
    end else if (m_wait || (v.req && !v.rdy)) begin
      m_wait = 1;
      if (m_waited < 255) m_waited++;
    end
    if (m_waited >= MW) m_to = 1;
  endtask

  task automatic step(vec_t v, bit use_tbl, string name);
    logic [6:0] got, exp;
    reset = v.rst; decRs1 = v.rs1; decRs2 = v.rs2; exeRd = v.rd;
    decUsesRs1 = v.u1; decUsesRs2 = v.u2; exeWrEn = v.wr;
    exeIsLoad = v.ld; exeRedirect = v.redir;
    memReq = v.req; memReady = v.rdy;
    @(negedge clk);
    got = {stallF, stallD, stallE, stallM, flushD, flushE, pcSelExec};
    exp = m_out(v);
    tests++;
    if (got !== exp || (use_tbl && got !== v.exp)) begin
      fails++;
      $display("FAIL %s ctl: got %b model %b table %b", name, got, exp,
               v.exp);
    end
    tests++;
    if (memTimeout !== m_to || (use_tbl && memTimeout !== v.to)) begin
      fails++;
      $display("FAIL %s timeout: got %b model %b table %b", name,
               memTimeout, m_to, v.to);
    end
    @(posedge clk);
    m_edge(v, exp);
    #1;
  endtask

  vec_t tbl[18];
  vec_t idle;
  vec_t v;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0, 0);
    //          rst rs1 rs2 rd u1 u2 wr ld rdr req rdy exp         to
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000110, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0000000, 0);
    tbl[2]  = mk(0, 3, 0, 3, 1, 0, 1, 1, 0, 0, 1, 7'b1100010, 0);
    tbl[3]  = mk(0, 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, 7'b0000000, 0);
    tbl[4]  = mk(0, 5, 5, 5, 0, 1, 1, 1, 0, 0, 1, 7'b1100010, 0);
    tbl[5]  = mk(0, 5, 6, 5, 0, 1, 1, 1, 0, 0, 1, 7'b0000000, 0);
    tbl[6]  = mk(0, 5, 0, 5, 1, 0, 0, 1, 0, 0, 1, 7'b0000000, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 7'b0000111, 0);
    tbl[8]  = mk(0, 1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 7'b0000000, 0);
    tbl[9]  = mk(0, 1, 2, 0, 1, 1, 0, 0, 1, 0, 1, 7'b0000111, 0);
    tbl[10] = mk(0, 7, 0, 7, 1, 0, 1, 1, 1, 0, 1, 7'b0000111, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 7'b1100010, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000, 0);
    tbl[13] = mk(0, 2, 0, 2, 1, 0, 1, 1, 1, 1, 0, 7'b1111000, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b0000000, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7'b0000111, 0);

    m_wait = 0; m_waited = 0; m_to = 0;
    m_stall = 0; m_flush = 0; m_mw = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++)
      step(tbl[i], 1, $sformatf("vec%0d", i));

    // timeout: wait 10 cycles, flag from 4th wait edge, sticky after
    for (int k = 0; k < 10; k++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000, k >= MW);
      step(v, 1, $sformatf("tmo%0d", k));
    end
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0, 1);
    step(v, 1, "tmo_rdy");
    v = idle; v.to = 1;
    step(v, 1, "tmo_sticky");

    // reset mid-wait clears flag and returns to RUN
    for (int k = 0; k < 6; k++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1111000, 1);
      step(v, 1, $sformatf("rw%0d", k));
    end
    v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000110, 1);
    step(v, 1, "rst_mid");
    step(idle, 1, "post_rst");

`ifdef PIPE_CTRL_PERF_EN
    // two-cycle load-use after reset
    step(tbl[0], 0, "p_rst");
    step(tbl[2], 0, "p_lu0");
    step(tbl[2], 0, "p_lu1");
    step(idle, 0, "p_idle");
    tests++;
    if (perfStallCycles !== 2 || perfFlushCount !== 2 ||
        perfMemWaitCycles !== 0) begin
      fails++;
      $display("FAIL perf_lu: got %0d/%0d/%0d want 2/2/0",
               perfStallCycles, perfFlushCount, perfMemWaitCycles);
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      v.rst = ($urandom_range(0, 99) < 2);
      v.rs1 = 4'($urandom_range(0, 3));
      v.rs2 = 4'($urandom_range(0, 3));
      v.rd = 4'($urandom_range(0, 3));
      v.u1 = 1'($urandom); v.u2 = 1'($urandom);
      v.wr = 1'($urandom); v.ld = 1'($urandom);
      v.redir = ($urandom_range(0, 3) == 0);
      v.req = ($urandom_range(0, 2) == 0);
      v.rdy = ($urandom_range(0, 9) < 6);
      v.exp = 7'b0; v.to = 0;
      step(v, 0, "rand");
`ifdef PIPE_CTRL_PERF_EN
      tests++;
      if (perfStallCycles !== 32'(m_stall) ||
          perfFlushCount !== 32'(m_flush) ||
          perfMemWaitCycles !== 32'(m_mw)) begin
        fails++;
        $display("FAIL perf_rand: got %0d/%0d/%0d model %0d/%0d/%0d",
                 perfStallCycles, perfFlushCount, perfMemWaitCycles,
                 m_stall, m_flush, m_mw);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
